// File: rtl/mul_issue_if.sv
// Issue-lane, multiplier and writeback signals shared between the multiply
// issue scheduler (slave) and its surroundings (master).
interface mul_issue_if #(
    parameter int SS    = 2,
    parameter int TAG_W = 3
);
    logic [SS-1:0]            req_valid;
    logic [SS-1:0][31:0]      req_a;
    logic [SS-1:0][31:0]      req_b;
    logic [SS-1:0][1:0]       req_mul_type;
    logic [SS-1:0][TAG_W-1:0] req_tag;
    logic [SS-1:0]            req_ready;

    logic                     mul_start;
    logic [31:0]              mul_a;
    logic [31:0]              mul_b;
    logic [1:0]               mul_type;
    logic                     mul_done;
    logic [63:0]              mul_p;

    logic                     res_valid;
    logic [TAG_W-1:0]         res_tag;
    logic [31:0]              res_value;
    logic                     res_ack;
    logic                     flush;

    modport master (
        output req_valid, req_a, req_b, req_mul_type, req_tag,
        output mul_done, mul_p, res_ack, flush,
        input  req_ready, mul_start, mul_a, mul_b, mul_type,
        input  res_valid, res_tag, res_value
    );

    modport slave (
        input  req_valid, req_a, req_b, req_mul_type, req_tag,
        input  mul_done, mul_p, res_ack, flush,
        output req_ready, mul_start, mul_a, mul_b, mul_type,
        output res_valid, res_tag, res_value
    );
endinterface

// File: rtl/mul_issue_scheduler.sv
// Round-robin issue scheduler for a shared multiplier: grants one lane,
// pulses start, waits for the product and holds the result until acked.
module mul_issue_scheduler #(
    parameter int SS    = 2,
    parameter int TAG_W = 3
) (
    input logic        clk,
    input logic        rst,
    mul_issue_if.slave bus
);
    localparam int PTR_W = (SS > 1) ? $clog2(SS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] win_s;
    logic [PTR_W-1:0] next_ptr_s;
    logic             found_s;
    logic             grant_fire_s;
    logic             capture_s;
    logic             mul_start_s;
    logic [SS-1:0]    req_ready_s;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [1:0]       type_r;
    logic [TAG_W-1:0] tag_r;
    logic [31:0]      res_value_r;

    // Only MUL returns the low word; every high-half variant returns the upper word.
    function automatic logic [31:0] select_result(input logic [1:0] mtype, input logic [63:0] prod);
        logic [31:0] sel;
        case (mtype)
            2'b00:               sel = prod[31:0];
            2'b01, 2'b10, 2'b11: sel = prod[63:32];
            default:             sel = prod[31:0];
        endcase
        return sel;
    endfunction

    // Round-robin pick: scan from the far end so the lane nearest rr_ptr_r wins last.
    always_comb begin
        logic [PTR_W-1:0] idx_s;
        idx_s   = {PTR_W{1'b0}};
        found_s = 1'b0;
        win_s   = {PTR_W{1'b0}};
        for (int off = SS - 1; off >= 0; off--) begin
            idx_s   = PTR_W'((int'(rr_ptr_r) + off) % SS);
            win_s   = bus.req_valid[idx_s] ? idx_s : win_s;
            found_s = found_s | bus.req_valid[idx_s];
        end
    end

    assign next_ptr_s = (win_s == PTR_W'(SS - 1)) ? {PTR_W{1'b0}} : (win_s + PTR_W'(1'b1));

    // Next-state and per-state control decode; flush always returns to idle.
    always_comb begin
        next_state_s = state_r;
        grant_fire_s = 1'b0;
        capture_s    = 1'b0;
        mul_start_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s && !bus.flush && !rst) begin
                    grant_fire_s = 1'b1;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                mul_start_s  = ~bus.flush;
                next_state_s = bus.flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.flush) begin
                    next_state_s = ST_IDLE;
                end else if (bus.mul_done) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_RESULT;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESULT: begin
                if (bus.flush || bus.res_ack) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESULT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // One-hot grant toward the round-robin winner.
    always_comb begin
        req_ready_s        = {SS{1'b0}};
        req_ready_s[win_s] = grant_fire_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Winner latch, round-robin pointer and captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r    <= {PTR_W{1'b0}};
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            type_r      <= 2'b00;
            tag_r       <= {TAG_W{1'b0}};
            res_value_r <= 32'd0;
        end else begin
            if (grant_fire_s) begin
                rr_ptr_r <= next_ptr_s;
                a_r      <= bus.req_a[win_s];
                b_r      <= bus.req_b[win_s];
                type_r   <= bus.req_mul_type[win_s];
                tag_r    <= bus.req_tag[win_s];
            end
            if (capture_s) begin
                res_value_r <= select_result(type_r, bus.mul_p);
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.mul_start = mul_start_s;
    assign bus.mul_a     = a_r;
    assign bus.mul_b     = b_r;
    assign bus.mul_type  = type_r;
    assign bus.res_valid = (state_r == ST_RESULT);
    assign bus.res_tag   = tag_r;
    assign bus.res_value = res_value_r;
endmodule

// File: tb/tb_mul_issue_scheduler.sv
// Self-checking bench for mul_issue_scheduler: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_mul_issue_scheduler;
    localparam int SS    = 2;
    localparam int TAG_W = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_ptr  = 0;

    mul_issue_if #(.SS(SS), .TAG_W(TAG_W)) bus ();

    mul_issue_scheduler #(.SS(SS), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Full 64-bit product with RISC-V signedness for each multiply type.
    function automatic logic [63:0] ref_product(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub_s;
        logic [63:0] ua;
        logic [63:0] ub;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub_s = longint'({32'd0, b});
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        case (t)
            2'b00, 2'b01: return 64'(sa * sb);
            2'b10:        return 64'(sa * ub_s);
            default:      return ua * ub;
        endcase
    endfunction

    function automatic logic [31:0] exp_result(input logic [1:0] t, input logic [63:0] p);
        return (t == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int model_pick(input logic [SS-1:0] m);
        for (int k = 0; k < SS; k++) begin
            if (m[(exp_ptr + k) % SS]) return (exp_ptr + k) % SS;
        end
        return 0;
    endfunction

    task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] t, input logic [TAG_W-1:0] g);
        bus.req_a[l]        = a;
        bus.req_b[l]        = b;
        bus.req_mul_type[l] = t;
        bus.req_tag[l]      = g;
    endtask

    // fmode: 0 normal, 1 flush in WAIT then late mul_done, 2 flush together with ack in RESULT.
    task automatic run_txn(input logic [SS-1:0] vmask, input int fmode, input int wait_cyc, input int ack_dly);
        int               w;
        logic [SS-1:0]    oh;
        logic [31:0]      ea;
        logic [31:0]      eb;
        logic [31:0]      ev;
        logic [1:0]       et;
        logic [TAG_W-1:0] eg;
        logic [63:0]      p;
        bus.req_valid = vmask;
        #1;
        w     = model_pick(vmask);
        oh    = '0;
        oh[w] = 1'b1;
        check_eq("grant", bus.req_ready, oh);
        ea      = bus.req_a[w];
        eb      = bus.req_b[w];
        et      = bus.req_mul_type[w];
        eg      = bus.req_tag[w];
        exp_ptr = (w + 1) % SS;
        @(negedge clk); #1;
        check_eq("start_pulse", bus.mul_start, 1);
        check_eq("start_a", bus.mul_a, ea);
        check_eq("start_b", bus.mul_b, eb);
        check_eq("start_type", bus.mul_type, et);
        check_eq("start_no_grant", bus.req_ready, 0);
        @(negedge clk); #1;
        check_eq("start_one_cycle", bus.mul_start, 0);
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk); #1;
            check_eq("wait_hold_a", bus.mul_a, ea);
            check_eq("wait_hold_type", bus.mul_type, et);
            check_eq("wait_no_grant", bus.req_ready, 0);
        end
        if (fmode == 1) begin
            bus.flush = 1'b1;
            #1;
            check_eq("flush_wait_no_grant", bus.req_ready, 0);
            @(negedge clk);
            bus.flush     = 1'b0;
            bus.req_valid = '0;
            #1;
            check_eq("flush_wait_no_result", bus.res_valid, 0);
            @(negedge clk);
            bus.mul_done = 1'b1;
            bus.mul_p    = 64'hDEAD_BEEF_0BAD_F00D;
            @(negedge clk);
            bus.mul_done = 1'b0;
            #1;
            check_eq("late_done_ignored", bus.res_valid, 0);
            check_eq("late_done_no_start", bus.mul_start, 0);
            return;
        end
        p  = ref_product(et, ea, eb);
        ev = exp_result(et, p);
        bus.mul_done = 1'b1;
        bus.mul_p    = p;
        @(negedge clk);
        bus.mul_done = 1'b0;
        #1;
        check_eq("res_valid", bus.res_valid, 1);
        check_eq("res_tag", bus.res_tag, eg);
        check_eq("res_value", bus.res_value, ev);
        for (int i = 0; i < ack_dly; i++) begin
            bus.mul_done = 1'b1;
            bus.mul_p    = ~p;
            @(negedge clk);
            bus.mul_done = 1'b0;
            #1;
            check_eq("bp_valid", bus.res_valid, 1);
            check_eq("bp_tag", bus.res_tag, eg);
            check_eq("bp_value", bus.res_value, ev);
            check_eq("bp_no_grant", bus.req_ready, 0);
        end
        if (fmode == 2) begin
            bus.flush   = 1'b1;
            bus.res_ack = 1'b1;
            #1;
            check_eq("flush_res_still_valid", bus.res_valid, 1);
            check_eq("flush_res_no_grant", bus.req_ready, 0);
            @(negedge clk);
            bus.flush     = 1'b0;
            bus.res_ack   = 1'b0;
            bus.req_valid = '0;
            #1;
            check_eq("flush_res_cleared", bus.res_valid, 0);
            return;
        end
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
        #1;
        check_eq("ack_cleared", bus.res_valid, 0);
        check_eq("ack_no_start", bus.mul_start, 0);
    endtask

    task automatic do_async_reset();
        #1 rst = 1'b1;
        #1;
        check_eq("arst_start", bus.mul_start, 0);
        check_eq("arst_ready", bus.req_ready, 0);
        check_eq("arst_res_valid", bus.res_valid, 0);
        check_eq("arst_a", bus.mul_a, 0);
        check_eq("arst_b", bus.mul_b, 0);
        check_eq("arst_type", bus.mul_type, 0);
        check_eq("arst_tag", bus.res_tag, 0);
        check_eq("arst_value", bus.res_value, 0);
        @(negedge clk);
        rst     = 1'b0;
        exp_ptr = 0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SS-1:0] vm;
        int            fm;
        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.req_mul_type = '0;
        bus.req_tag      = '0;
        bus.mul_done     = 1'b0;
        bus.mul_p        = 64'd0;
        bus.res_ack      = 1'b0;
        bus.flush        = 1'b0;

        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_start", bus.mul_start, 0);
        check_eq("rst_res_valid", bus.res_valid, 0);
        check_eq("rst_a", bus.mul_a, 0);
        check_eq("rst_value", bus.res_value, 0);
        check_eq("rst_tag", bus.res_tag, 0);
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle_no_grant", bus.req_ready, 0);

        // Single lane 7x6, then the same lane alone with the pointer moved past it.
        set_lane(0, 32'd7, 32'd6, 2'b00, 3'd2);
        set_lane(1, 32'h1234, 32'h5678, 2'b01, 3'd6);
        run_txn(2'b01, 0, 0, 0);
        run_txn(2'b01, 0, 1, 0);

        // High-word and low-word selection on all-ones operands.
        set_lane(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 3'd5);
        run_txn(2'b10, 0, 2, 0);
        set_lane(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 3'd3);
        run_txn(2'b01, 0, 0, 1);
        set_lane(0, 32'h8000_0000, 32'h0000_0003, 2'b10, 3'd1);
        set_lane(1, 32'h8000_0000, 32'h0000_0003, 2'b01, 3'd4);

        // Backpressure, flush in WAIT, flush in IDLE, flush with ack.
        run_txn(2'b11, 0, 1, 5);
        run_txn(2'b11, 1, 1, 0);
        bus.req_valid = 2'b11;
        bus.flush     = 1'b1;
        #1;
        check_eq("flush_idle_no_grant", bus.req_ready, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check_eq("flush_idle_no_start", bus.mul_start, 0);
        run_txn(2'b11, 0, 0, 0);
        run_txn(2'b11, 2, 0, 1);

        // Contention from a freshly reset pointer.
        do_async_reset();
        run_txn(2'b11, 0, 0, 0);
        run_txn(2'b11, 0, 0, 0);
        run_txn(2'b11, 0, 1, 0);
        bus.req_valid = '0;

        // Asynchronous reset while in START.
        @(negedge clk);
        bus.req_valid = 2'b10;
        #1;
        check_eq("pre_arst_grant", bus.req_ready, 2'b10);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check_eq("pre_arst_start", bus.mul_start, 1);
        do_async_reset();
        run_txn(2'b11, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            for (int l = 0; l < SS; l++) begin
                set_lane(l, $urandom, $urandom, 2'($urandom_range(0, 3)), TAG_W'($urandom));
            end
            vm = SS'($urandom_range(1, (1 << SS) - 1));
            fm = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
            run_txn(vm, fm, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        bus.req_valid = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
